// File: rtl/rf_pkg.sv
// rtl/rf_pkg.sv - shared constants, types and helpers for the scoreboarded register file
//
// Purpose: holds the default geometry of the register file, the popcount
//          helper used by the pending-write counter, and the register word type.
// Ports:   none (package).
// Optional feature macro used by importers: RF_BYPASS_EN.
package rf_pkg;

  localparam int DW_DEF  = 8;
  localparam int AW_DEF  = 3;
  localparam int NRD_DEF = 2;

  // popcount is written once for the widest scoreboard supported (AW up to
  // MAX_AW). Callers zero-extend their busy vector to PC_W bits and narrow
  // the result back to AW+1 bits.
  localparam int MAX_AW = 6;
  localparam int PC_W   = 2 ** MAX_AW;

  typedef logic [DW_DEF-1:0] rf_word_t;

  function automatic logic [MAX_AW:0] popcount(input logic [PC_W-1:0] v);
    logic [MAX_AW:0] c;
    c = '0;
    for (int i = 0; i < PC_W; i++) begin
      c = c + (MAX_AW+1)'(v[i]);
    end
    return c;
  endfunction

endpackage

// File: rtl/rf_bank.sv
// rtl/rf_bank.sv - register storage array with async clear, one write port, NRD read ports
//
// Purpose: plain storage for the scoreboarded register file. Reads are
//          combinational; a write lands on the rising edge.
// Ports:
//   clk    in   clock
//   rst_n  in   asynchronous active-low clear of every register
//   we     in   write enable
//   waddr  in   write address (AW)
//   wdata  in   write data (DW)
//   raddr  in   packed read addresses, port i at [i*AW +: AW]
//   rdata  out  packed read data, port i at [i*DW +: DW]
module rf_bank
  import rf_pkg::*;
#(
  parameter int DW  = DW_DEF,
  parameter int AW  = AW_DEF,
  parameter int NRD = NRD_DEF
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              we,
  input  logic [AW-1:0]     waddr,
  input  logic [DW-1:0]     wdata,
  input  logic [NRD*AW-1:0] raddr,
  output logic [NRD*DW-1:0] rdata
);

  localparam int DEPTH = 2 ** AW;

  logic [DW-1:0] mem_q [DEPTH];
  logic [DW-1:0] mem_d [DEPTH];

  always_comb begin
    mem_d = mem_q;
    if (we) begin
      mem_d[waddr] = wdata;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      mem_q <= '{default: '0};
    end else begin
      mem_q <= mem_d;
    end
  end

  always_comb begin
    rdata = '0;
    for (int i = 0; i < NRD; i++) begin
      rdata[i*DW +: DW] = mem_q[raddr[i*AW +: AW]];
    end
  end

endmodule

// File: rtl/rf_scoreboard.sv
// rtl/rf_scoreboard.sv - register file with per-register busy scoreboard, pending counter and error flag
//
// Purpose: wraps rf_bank and tracks which registers await writeback so decode
//          can stall on RAW hazards. A reservation marks a register busy; a
//          writeback stores data and clears busy. Reserving a register that is
//          already busy (and not being written the same cycle) sets a sticky
//          error. Supports AW up to rf_pkg::MAX_AW.
// Optional: define RF_BYPASS_EN to forward the writeback data and a clear busy
//           flag to any read port addressing the register being written.
// Ports:
//   Clk       in   clock
//   Rst_n     in   asynchronous active-low reset
//   We        in   writeback enable
//   Waddr     in   writeback address (AW)
//   In        in   writeback data (DW)
//   Rsv       in   reserve request (mark Rsv_addr busy)
//   Rsv_addr  in   register to reserve (AW)
//   Raddr     in   packed read addresses, port i at [i*AW +: AW]
//   Out       out  packed read data, port i at [i*DW +: DW]
//   Busy      out  per-port busy flag of the addressed register
//   Busy_vec  out  raw scoreboard bits (DEPTH)
//   Pend_cnt  out  registered number of set busy bits (AW+1)
//   Err       out  sticky double-reservation error
module rf_scoreboard
  import rf_pkg::*;
#(
  parameter int DW  = DW_DEF,
  parameter int AW  = AW_DEF,
  parameter int NRD = NRD_DEF
) (
  input  logic                Clk,
  input  logic                Rst_n,
  input  logic                We,
  input  logic [AW-1:0]       Waddr,
  input  logic [DW-1:0]       In,
  input  logic                Rsv,
  input  logic [AW-1:0]       Rsv_addr,
  input  logic [NRD*AW-1:0]   Raddr,
  output logic [NRD*DW-1:0]   Out,
  output logic [NRD-1:0]      Busy,
  output logic [(2**AW)-1:0]  Busy_vec,
  output logic [AW:0]         Pend_cnt,
  output logic                Err
);

  localparam int DEPTH = 2 ** AW;

  logic [DEPTH-1:0]  busy_q, busy_d;
  logic [AW:0]       pend_cnt_q, pend_cnt_d;
  logic              err_q, err_d;
  logic [NRD*DW-1:0] bank_rdata;

  rf_bank #(
    .DW  (DW),
    .AW  (AW),
    .NRD (NRD)
  ) u_bank (
    .clk   (Clk),
    .rst_n (Rst_n),
    .we    (We),
    .waddr (Waddr),
    .wdata (In),
    .raddr (Raddr),
    .rdata (bank_rdata)
  );

  always_comb begin
    busy_d = busy_q;
    // Clear first, then set: on a same-address write+reserve the new
    // producer's reservation wins.
    if (We) begin
      busy_d[Waddr] = 1'b0;
    end
    if (Rsv) begin
      busy_d[Rsv_addr] = 1'b1;
    end

    // WAW double-issue: reserving a busy register whose old producer is not
    // retiring in this same cycle.
    err_d = err_q;
    if (Rsv && busy_q[Rsv_addr] && !(We && (Waddr == Rsv_addr))) begin
      err_d = 1'b1;
    end

    // Counting the next-state vector keeps Pend_cnt exactly in step with
    // Busy_vec, whatever combination of reserve and writeback occurred.
    pend_cnt_d = (AW+1)'(popcount(PC_W'(busy_d)));
  end

  always_ff @(posedge Clk or negedge Rst_n) begin
    if (!Rst_n) begin
      busy_q     <= '0;
      pend_cnt_q <= '0;
      err_q      <= 1'b0;
    end else begin
      busy_q     <= busy_d;
      pend_cnt_q <= pend_cnt_d;
      err_q      <= err_d;
    end
  end

  always_comb begin
    Out  = bank_rdata;
    Busy = '0;
    for (int i = 0; i < NRD; i++) begin
      Busy[i] = busy_q[Raddr[i*AW +: AW]];
`ifdef RF_BYPASS_EN
      // Forward the writeback so the consumer can issue this cycle.
      if (We && (Waddr == Raddr[i*AW +: AW])) begin
        Out[i*DW +: DW] = In;
        Busy[i]         = 1'b0;
      end
`endif
    end
  end

  assign Busy_vec = busy_q;
  assign Pend_cnt = pend_cnt_q;
  assign Err      = err_q;

endmodule

// File: tb/tb_rf_scoreboard.sv
// tb/tb_rf_scoreboard.sv - directed self-checking bench for rf_scoreboard
module tb_rf_scoreboard;

  logic        clk;
  logic        rst_n;
  logic        we;
  logic [2:0]  waddr;
  logic [7:0]  wdata;
  logic        rsv;
  logic [2:0]  rsv_addr;
  logic [5:0]  raddr;
  logic [15:0] out;
  logic [1:0]  busy;
  logic [7:0]  busy_vec;
  logic [3:0]  pend_cnt;
  logic        err;

  int checks = 0;
  int errors = 0;

  rf_scoreboard #(
    .DW  (8),
    .AW  (3),
    .NRD (2)
  ) dut (
    .Clk      (clk),
    .Rst_n    (rst_n),
    .We       (we),
    .Waddr    (waddr),
    .In       (wdata),
    .Rsv      (rsv),
    .Rsv_addr (rsv_addr),
    .Raddr    (raddr),
    .Out      (out),
    .Busy     (busy),
    .Busy_vec (busy_vec),
    .Pend_cnt (pend_cnt),
    .Err      (err)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic idle();
    we  = 1'b0;
    rsv = 1'b0;
  endtask

  task automatic test_reset();
    #1;
    checks++; if (busy_vec !== 8'h00) begin errors++; $display("FAIL reset_busy_vec: got %h want 00", busy_vec); end
    checks++; if (pend_cnt !== 4'd0)  begin errors++; $display("FAIL reset_pend_cnt: got %0d want 0", pend_cnt); end
    checks++; if (err !== 1'b0)       begin errors++; $display("FAIL reset_err: got %b want 0", err); end
    checks++; if (out !== 16'h0000)   begin errors++; $display("FAIL reset_out: got %h want 0000", out); end
    tick();
    rst_n = 1'b1;
    // preload r3, reserve r6 twice to raise Err
    we = 1'b1; waddr = 3'd3; wdata = 8'hA5;
    rsv = 1'b1; rsv_addr = 3'd6;
    tick();
    we = 1'b0;
    tick();
    idle();
    raddr = {3'd3, 3'd3};
    #1;
    checks++; if (out !== 16'hA5A5)  begin errors++; $display("FAIL preload_out: got %h want a5a5", out); end
    checks++; if (pend_cnt !== 4'd1) begin errors++; $display("FAIL preload_pend: got %0d want 1", pend_cnt); end
    checks++; if (err !== 1'b1)      begin errors++; $display("FAIL preload_err: got %b want 1", err); end
    // async reset between edges
    #1 rst_n = 1'b0;
    #1;
    checks++; if (out !== 16'h0000)  begin errors++; $display("FAIL async_out: got %h want 0000", out); end
    checks++; if (busy_vec !== 8'h00) begin errors++; $display("FAIL async_busy_vec: got %h want 00", busy_vec); end
    checks++; if (pend_cnt !== 4'd0) begin errors++; $display("FAIL async_pend: got %0d want 0", pend_cnt); end
    checks++; if (err !== 1'b0)      begin errors++; $display("FAIL async_err: got %b want 0", err); end
    #1 rst_n = 1'b1;
  endtask

  task automatic test_basic_rw();
    tick();
    we = 1'b1; waddr = 3'd5; wdata = 8'h3C;
    tick();
    idle();
    raddr = {3'd5, 3'd5};
    #1;
    checks++; if (out !== 16'h3C3C) begin errors++; $display("FAIL basic_out: got %h want 3c3c", out); end
    checks++; if (busy !== 2'b00)   begin errors++; $display("FAIL basic_busy: got %b want 00", busy); end
  endtask

  task automatic test_reserve_writeback();
    rsv = 1'b1; rsv_addr = 3'd2;
    tick();
    idle();
    raddr = {3'd5, 3'd2};
    #1;
    checks++; if (busy_vec !== 8'b0000_0100) begin errors++; $display("FAIL rsv_busy_vec: got %b want 00000100", busy_vec); end
    checks++; if (pend_cnt !== 4'd1) begin errors++; $display("FAIL rsv_pend: got %0d want 1", pend_cnt); end
    checks++; if (busy !== 2'b01)    begin errors++; $display("FAIL rsv_busy_port: got %b want 01", busy); end
    we = 1'b1; waddr = 3'd2; wdata = 8'h11;
    tick();
    idle();
    #1;
    checks++; if (busy_vec !== 8'h00) begin errors++; $display("FAIL wb_busy_vec: got %h want 00", busy_vec); end
    checks++; if (pend_cnt !== 4'd0)  begin errors++; $display("FAIL wb_pend: got %0d want 0", pend_cnt); end
    checks++; if (out[7:0] !== 8'h11) begin errors++; $display("FAIL wb_out: got %h want 11", out[7:0]); end
  endtask

  task automatic test_same_cycle();
    rsv = 1'b1; rsv_addr = 3'd7;
    tick();
    we = 1'b1; waddr = 3'd7; wdata = 8'h5A;
    rsv = 1'b1; rsv_addr = 3'd7;
    tick();
    idle();
    raddr = {3'd7, 3'd0};
    #1;
    checks++; if (busy_vec !== 8'h80)  begin errors++; $display("FAIL same_busy_vec: got %h want 80", busy_vec); end
    checks++; if (pend_cnt !== 4'd1)   begin errors++; $display("FAIL same_pend: got %0d want 1", pend_cnt); end
    checks++; if (err !== 1'b0)        begin errors++; $display("FAIL same_err: got %b want 0", err); end
    checks++; if (out[15:8] !== 8'h5A) begin errors++; $display("FAIL same_out: got %h want 5a", out[15:8]); end
    // write r7 and reserve r0 together: independent effects
    we = 1'b1; waddr = 3'd7; wdata = 8'h77;
    rsv = 1'b1; rsv_addr = 3'd0;
    tick();
    idle();
    #1;
    checks++; if (busy_vec !== 8'h01)  begin errors++; $display("FAIL diff_busy_vec: got %h want 01", busy_vec); end
    checks++; if (pend_cnt !== 4'd1)   begin errors++; $display("FAIL diff_pend: got %0d want 1", pend_cnt); end
    checks++; if (out[15:8] !== 8'h77) begin errors++; $display("FAIL diff_out: got %h want 77", out[15:8]); end
    we = 1'b1; waddr = 3'd0; wdata = 8'h00;
    tick();
    idle();
  endtask

  task automatic test_bypass();
    we = 1'b1; waddr = 3'd1; wdata = 8'h22;
    tick();
    idle();
    rsv = 1'b1; rsv_addr = 3'd1;
    tick();
    idle();
    we = 1'b1; waddr = 3'd1; wdata = 8'hF0;
    raddr = {3'd3, 3'd1};
    #1;
`ifdef RF_BYPASS_EN
    checks++; if (out[7:0] !== 8'hF0) begin errors++; $display("FAIL bypass_out: got %h want f0", out[7:0]); end
    checks++; if (busy[0] !== 1'b0)   begin errors++; $display("FAIL bypass_busy: got %b want 0", busy[0]); end
`else
    checks++; if (out[7:0] !== 8'h22) begin errors++; $display("FAIL nobypass_out: got %h want 22", out[7:0]); end
    checks++; if (busy[0] !== 1'b1)   begin errors++; $display("FAIL nobypass_busy: got %b want 1", busy[0]); end
`endif
    checks++; if (out[15:8] !== 8'h00) begin errors++; $display("FAIL bypass_port1: got %h want 00", out[15:8]); end
    checks++; if (busy_vec !== 8'h02)  begin errors++; $display("FAIL bypass_busy_vec: got %h want 02", busy_vec); end
    tick();
    idle();
    #1;
    checks++; if (out[7:0] !== 8'hF0) begin errors++; $display("FAIL bypass_after_out: got %h want f0", out[7:0]); end
    checks++; if (busy[0] !== 1'b0)   begin errors++; $display("FAIL bypass_after_busy: got %b want 0", busy[0]); end
    checks++; if (pend_cnt !== 4'd0)  begin errors++; $display("FAIL bypass_after_pend: got %0d want 0", pend_cnt); end
  endtask

  task automatic test_back_to_back();
    logic [7:0] exp_vec;
    for (int i = 0; i < 8; i++) begin
      rsv = 1'b1; rsv_addr = 3'(i);
      tick();
    end
    idle();
    #1;
    checks++; if (busy_vec !== 8'hFF) begin errors++; $display("FAIL full_busy_vec: got %h want ff", busy_vec); end
    checks++; if (pend_cnt !== 4'd8)  begin errors++; $display("FAIL full_pend: got %0d want 8", pend_cnt); end
    checks++; if (err !== 1'b0)       begin errors++; $display("FAIL full_err: got %b want 0", err); end
    exp_vec = 8'hFF;
    for (int i = 0; i < 8; i++) begin
      we = 1'b1; waddr = 3'(i); wdata = 8'(i * 17 + 1);
      tick();
      exp_vec[i] = 1'b0;
      checks++; if (busy_vec !== exp_vec) begin errors++; $display("FAIL drain_busy_vec%0d: got %h want %h", i, busy_vec, exp_vec); end
      checks++; if (pend_cnt !== 4'(7 - i)) begin errors++; $display("FAIL drain_pend%0d: got %0d want %0d", i, pend_cnt, 7 - i); end
    end
    idle();
    for (int i = 0; i < 8; i += 2) begin
      raddr = {3'(i + 1), 3'(i)};
      #1;
      checks++; if (out !== {8'((i + 1) * 17 + 1), 8'(i * 17 + 1)}) begin errors++; $display("FAIL b2b_read%0d: got %h want %h", i, out, {8'((i + 1) * 17 + 1), 8'(i * 17 + 1)}); end
    end
  endtask

  task automatic test_double_reserve();
    rsv = 1'b1; rsv_addr = 3'd4;
    tick();
    checks++; if (err !== 1'b0) begin errors++; $display("FAIL dbl_first_err: got %b want 0", err); end
    rsv = 1'b1; rsv_addr = 3'd4;
    tick();
    idle();
    #1;
    checks++; if (err !== 1'b1)       begin errors++; $display("FAIL dbl_err: got %b want 1", err); end
    checks++; if (pend_cnt !== 4'd1)  begin errors++; $display("FAIL dbl_pend: got %0d want 1", pend_cnt); end
    checks++; if (busy_vec !== 8'h10) begin errors++; $display("FAIL dbl_busy_vec: got %h want 10", busy_vec); end
    we = 1'b1; waddr = 3'd4; wdata = 8'h44;
    tick();
    idle();
    tick();
    checks++; if (err !== 1'b1)      begin errors++; $display("FAIL dbl_sticky: got %b want 1", err); end
    checks++; if (pend_cnt !== 4'd0) begin errors++; $display("FAIL dbl_cleared_pend: got %0d want 0", pend_cnt); end
    rst_n = 1'b0;
    #1;
    checks++; if (err !== 1'b0) begin errors++; $display("FAIL dbl_reset_err: got %b want 0", err); end
    rst_n = 1'b1;
  endtask

  initial begin
    rst_n    = 1'b0;
    we       = 1'b0;
    waddr    = '0;
    wdata    = '0;
    rsv      = 1'b0;
    rsv_addr = '0;
    raddr    = '0;
    test_reset();
    test_basic_rw();
    test_reserve_writeback();
    test_same_cycle();
    test_bypass();
    test_back_to_back();
    test_double_reserve();
    tick();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
